// File: rtl/mips_pipe_pkg.sv
// Shared pipeline constants: hold-vector encodings, stall FSM states, PC width,
// and the priority mux that builds the hold vector.
package mips_pipe_pkg;

    localparam int unsigned PC_W = 32;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MC_BUSY = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    // Priority: flush > EX-level stall (multi-cycle or EX hazard) > ID load-use.
    function automatic logic [5:0] hold_vec(input logic flush_any,
                                            input logic ex_stall,
                                            input logic id_stall);
        logic [5:0] v;
        v = STALL_NONE;
        if (flush_any)
            v = STALL_NONE;
        else if (ex_stall)
            v = STALL_EX;
        else if (id_stall)
            v = STALL_ID;
        return v;
    endfunction

endpackage

// File: rtl/mc_cycle_counter.sv
// Remaining-cycle counter for multi-cycle EX ops: load, self-decrement to zero,
// abort clears it, and last/more flags report the position in the op.
module mc_cycle_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             abort,
    output logic             last,
    output logic             more
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (abort)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign last = (cnt == CNT_W'(1));
    assign more = (cnt >  CNT_W'(1));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: drives the pipeline hold vector, sequences
// multi-cycle EX ops, issues redirect flushes and counts stall cycles.
module pipeline_stall_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int unsigned CNT_W  = 6,
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              mc_start,
    input  logic [CNT_W-1:0]  mc_cycles,
    input  logic              flush_req,
    input  logic [PC_W-1:0]   flush_pc,
    output logic [5:0]        control,
    output logic              flush,
    output logic [PC_W-1:0]   new_pc_output,
    output logic              mc_busy,
    output logic              mc_done,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    state_t           state, next_state;
    logic             cnt_last, cnt_more;
    logic             cnt_load;
    logic             short_op;
    logic             flush_any;
    logic             mc_stall;
    logic [CNT_W-1:0] load_val;

    // mc_cycles of 0 behaves as 1; the counter holds the cycles left after the start cycle.
    assign short_op = (mc_cycles <= CNT_W'(1));
    assign load_val = short_op ? '0 : mc_cycles - CNT_W'(1);
    assign cnt_load = (state == ST_IDLE) && mc_start && !short_op && !flush_req;

    mc_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_mc_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (load_val),
        .abort    (flush_req),
        .last     (cnt_last),
        .more     (cnt_more)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (flush_req) begin
            next_state = ST_FLUSH;
        end else begin
            case (state)
                ST_IDLE:    if (mc_start && !short_op) next_state = ST_MC_BUSY;
                ST_MC_BUSY: if (cnt_last) next_state = ST_IDLE;
                ST_FLUSH:   next_state = ST_IDLE;
                default:    next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        flush_any = 1'b0;
        mc_stall  = 1'b0;
        mc_done   = 1'b0;
        mc_busy   = 1'b0;
        control   = STALL_NONE;
        if (!rst) begin
            flush_any = flush_req || (state == ST_FLUSH);
            mc_stall  = !flush_any &&
                        (((state == ST_IDLE) && mc_start && !short_op) ||
                         ((state == ST_MC_BUSY) && cnt_more));
            // A flush in the final cycle aborts the op, so no done pulse.
            mc_done   = !flush_any &&
                        (((state == ST_IDLE) && mc_start && short_op) ||
                         ((state == ST_MC_BUSY) && cnt_last));
            mc_busy   = (state == ST_MC_BUSY);
            control   = hold_vec(flush_any, mc_stall || stallreq_ex, stallreq_id);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush         <= 1'b0;
            new_pc_output <= '0;
        end else begin
            flush <= flush_req;
            if (flush_req)
                new_pc_output <= flush_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_stall_cnt <= '0;
        else if (control[0] && (perf_stall_cnt != '1))
            perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
    end

endmodule
